apb3_bridge_n: RTL and testbench



---
 rtl/apb3_bridge_n.sv | 213 +++++++++++++++++++++
 tb/tb_apb3_bridge_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_bridge_n.sv
// Registered APB3 bridge: one master fanned out to up to 16 slave slots with registered decode.
// Optional ACCESS-phase watchdog (counter, abort path, TOUT) is built when APB3_TIMEOUT_EN is defined.
module apb3_bridge_n #(
    parameter int unsigned APB_DWIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned MADDR_BITS     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             PCLK,
    input  logic                             PRESETN,
    input  logic [31:0]                      PADDR,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [APB_DWIDTH-1:0]            PWDATA,
    output logic [APB_DWIDTH-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    output logic [31:0]                      PADDRS,
    output logic                             PWRITES,
    output logic                             PENABLES,
    output logic [APB_DWIDTH-1:0]            PWDATAS,
    output logic [NUM_SLAVES-1:0]            PSELS,
    input  logic [NUM_SLAVES*APB_DWIDTH-1:0] PRDATAS,
    input  logic [NUM_SLAVES-1:0]            PREADYS,
    input  logic [NUM_SLAVES-1:0]            PSLVERRS,
    output logic                             TOUT
);
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned SLOT_W     = 4;
    localparam int unsigned SLOT_CMP_W = SLOT_W + 1;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SLOT_W-1:0]     r_slot;
    logic [SLOT_W-1:0]     w_req_slot;
    logic [SLOT_W-1:0]     w_slot_nxt;
    logic                  w_accept;
    logic                  w_req_mapped;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [APB_DWIDTH-1:0] w_sel_rdata;
    logic                  w_abort;
    logic                  w_err_nxt;
    logic [APB_DWIDTH-1:0] w_rdata_nxt;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [NUM_SLAVES-1:0] w_psels_nxt;
    logic                  w_penables_nxt;
    logic                  w_pready_nxt;
    logic                  w_pslverr_nxt;
    logic [APB_DWIDTH-1:0] w_prdata_nxt;

    logic [APB_DWIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [ADDR_W-1:0]     r_paddrs;
    logic                  r_pwrites;
    logic                  r_penables;
    logic [APB_DWIDTH-1:0] r_pwdatas;
    logic [NUM_SLAVES-1:0] r_psels;

    assign w_req_slot   = PADDR[MADDR_BITS-1 -: SLOT_W];
    assign w_req_mapped = ({1'b0, w_req_slot} < SLOT_CMP_W'(NUM_SLAVES));
    assign w_accept     = (r_state == S_IDLE) && PSEL && !PENABLE;
    assign w_slot_nxt   = w_accept ? w_req_slot : r_slot;

    // Only the addressed slot's response is looked at.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_sel_ready = PREADYS[k];
                w_sel_err   = PSLVERRS[k];
                w_sel_rdata = PRDATAS[k*APB_DWIDTH +: APB_DWIDTH];
            end
        end
    end

`ifdef APB3_TIMEOUT_EN
    logic [CNT_W-1:0] r_tcnt;
    logic             r_tout;

    assign w_abort = (r_state == S_ACCESS) && !w_sel_ready &&
                     (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturating wait counter, restarted for every mapped transfer.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_tcnt <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_abort;
            if (r_state == S_SETUP) begin
                r_tcnt <= '0;
            end else if ((r_state == S_ACCESS) && !w_sel_ready && (r_tcnt != '1)) begin
                r_tcnt <= r_tcnt + CNT_W'(1);
            end
        end
    end

    assign TOUT = r_tout;
`else
    logic [CNT_W-1:0] w_unused_timeout;

    assign w_unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign w_abort          = 1'b0;
    assign TOUT             = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_req_mapped ? S_SETUP : S_DONE;
                end
            end
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (w_sel_ready || w_abort) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Completion defaults to an error with zero data (unmapped or aborted).
    always_comb begin
        w_err_nxt      = 1'b1;
        w_rdata_nxt    = '0;
        w_psels_nxt    = '0;
        w_penables_nxt = 1'b0;
        w_pready_nxt   = 1'b0;
        w_pslverr_nxt  = 1'b0;
        w_prdata_nxt   = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            w_onehot[k] = (w_slot_nxt == SLOT_W'(k));
        end
        if ((r_state == S_ACCESS) && w_sel_ready) begin
            w_err_nxt   = w_sel_err;
            w_rdata_nxt = r_pwrites ? '0 : w_sel_rdata;
        end
        case (w_state_nxt)
            S_SETUP:  w_psels_nxt = w_onehot;
            S_ACCESS: begin
                w_psels_nxt    = w_onehot;
                w_penables_nxt = 1'b1;
            end
            S_DONE: begin
                w_pready_nxt  = 1'b1;
                w_pslverr_nxt = w_err_nxt;
                w_prdata_nxt  = w_rdata_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_slot     <= '0;
            r_paddrs   <= '0;
            r_pwrites  <= 1'b0;
            r_pwdatas  <= '0;
            r_psels    <= '0;
            r_penables <= 1'b0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
        end else begin
            if (w_accept) begin
                r_slot    <= w_req_slot;
                r_paddrs  <= PADDR;
                r_pwrites <= PWRITE;
                r_pwdatas <= PWDATA;
            end
            r_psels    <= w_psels_nxt;
            r_penables <= w_penables_nxt;
            r_pready   <= w_pready_nxt;
            r_pslverr  <= w_pslverr_nxt;
            r_prdata   <= w_prdata_nxt;
        end
    end

    assign PRDATA   = r_prdata;
    assign PREADY   = r_pready;
    assign PSLVERR  = r_pslverr;
    assign PADDRS   = r_paddrs;
    assign PWRITES  = r_pwrites;
    assign PENABLES = r_penables;
    assign PWDATAS  = r_pwdatas;
    assign PSELS    = r_psels;

endmodule

// File: tb/tb_apb3_bridge_n.sv
// Randomized bench for apb3_bridge_n: a transaction-level model predicts latency, error and read data.
module tb_apb3_bridge_n;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned MB = 20;
    localparam int unsigned TO = 8;
`ifdef APB3_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic             PCLK = 1'b0;
    logic             PRESETN;
    logic [31:0]      PADDR;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [31:0]      PADDRS;
    logic             PWRITES;
    logic             PENABLES;
    logic [DW-1:0]    PWDATAS;
    logic [NS-1:0]    PSELS;
    logic [NS*DW-1:0] PRDATAS;
    logic [NS-1:0]    PREADYS;
    logic [NS-1:0]    PSLVERRS;
    logic             TOUT;

    int n_checks = 0;
    int n_errors = 0;

    apb3_bridge_n #(
        .APB_DWIDTH(DW), .NUM_SLAVES(NS), .MADDR_BITS(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PADDRS(PADDRS), .PWRITES(PWRITES), .PENABLES(PENABLES),
        .PWDATAS(PWDATAS), .PSELS(PSELS), .PRDATAS(PRDATAS), .PREADYS(PREADYS),
        .PSLVERRS(PSLVERRS), .TOUT(TOUT)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_prdata"},   64'(PRDATA),   64'd0);
        check({tag, "_pready"},   64'(PREADY),   64'd0);
        check({tag, "_pslverr"},  64'(PSLVERR),  64'd0);
        check({tag, "_paddrs"},   64'(PADDRS),   64'd0);
        check({tag, "_pwrites"},  64'(PWRITES),  64'd0);
        check({tag, "_penables"}, 64'(PENABLES), 64'd0);
        check({tag, "_pwdatas"},  64'(PWDATAS),  64'd0);
        check({tag, "_psels"},    64'(PSELS),    64'd0);
        check({tag, "_tout"},     64'(TOUT),     64'd0);
    endtask

    // Random responses on every slot except the addressed one.
    task automatic noise(input int tgt);
        for (int k = 0; k < int'(NS); k++) begin
            if (k != tgt) begin
                PRDATAS[k*DW +: DW] = $urandom;
                PREADYS[k]          = 1'($urandom_range(0, 1));
                PSLVERRS[k]         = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // One master transfer; the addressed slave inserts 'waits' wait states then responds.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int waits, input logic serr, input logic [31:0] srd);
        int            slot;
        bit            mapped;
        int            acc;
        int            n;
        bit            seen;
        int            exp_lat;
        logic          exp_err;
        logic          exp_tout;
        logic [31:0]   exp_rd;
        logic [NS-1:0] oh;
        slot   = int'(addr[MB-1 -: 4]);
        mapped = (slot < int'(NS));
        oh     = '0;
        if (mapped) oh[slot] = 1'b1;
        if (!mapped) begin
            exp_lat = 1; exp_err = 1'b1; exp_rd = '0; exp_tout = 1'b0;
        end else if (TOUT_EN && waits >= int'(TO)) begin
            exp_lat = 2 + int'(TO); exp_err = 1'b1; exp_rd = '0; exp_tout = 1'b1;
        end else begin
            exp_lat = 3 + waits; exp_err = serr; exp_rd = wr ? 32'd0 : srd; exp_tout = 1'b0;
        end

        @(negedge PCLK);
        check("idle_pready", 64'(PREADY), 64'd0);
        check("idle_psels",  64'(PSELS),  64'd0);
        PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
        noise(slot);
        if (mapped) begin
            PREADYS[slot] = 1'b0; PSLVERRS[slot] = serr; PRDATAS[slot*DW +: DW] = srd;
        end
        acc = 0; n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge PCLK);
            n++;
            PENABLE = 1'b1;
            if (PREADY === 1'b1) begin
                seen = 1'b1;
                check("latency",       64'(n),        64'(exp_lat));
                check("pslverr",       64'(PSLVERR),  64'(exp_err));
                check("prdata",        64'(PRDATA),   64'(exp_rd));
                check("tout",          64'(TOUT),     64'(exp_tout));
                check("done_psels",    64'(PSELS),    64'd0);
                check("done_penables", 64'(PENABLES), 64'd0);
                check("paddrs",        64'(PADDRS),   64'(addr));
                check("pwrites",       64'(PWRITES),  64'(wr));
                check("pwdatas",       64'(PWDATAS),  64'(wd));
                PSEL = 1'b0; PENABLE = 1'b0;
            end else begin
                check("busy_tout", 64'(TOUT), 64'd0);
                if (mapped) begin
                    check("busy_psels",    64'(PSELS),    64'(oh));
                    check("busy_penables", 64'(PENABLES), (n == 1) ? 64'd0 : 64'd1);
                    if (PSELS[slot] && PENABLES) acc++;
                end else begin
                    check("unmapped_psels", 64'(PSELS), 64'd0);
                end
                noise(slot);
                if (mapped) PREADYS[slot] = PSELS[slot] && PENABLES && (acc > waits);
            end
        end
        if (!seen) begin
            check("xfer_hang", 64'd0, 64'd1);
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          w;
        bit          ok;
        PRESETN = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; PRDATAS = '0; PREADYS = '0; PSLVERRS = '0;

        // Reset held with random master/slave activity.
        repeat (5) begin
            @(negedge PCLK);
            check_zero("rst");
            PADDR = $urandom; PSEL = 1'($urandom_range(0, 1)); PENABLE = 1'($urandom_range(0, 1));
            PWRITE = 1'($urandom_range(0, 1)); PWDATA = $urandom; noise(-1);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETN = 1'b1;
        repeat (10) begin
            @(negedge PCLK);
            check_zero("post_rst");
            PADDR = $urandom; PWDATA = $urandom; noise(-1);
        end

        // Directed cases.
        xfer(32'h0002_0010, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h1234_5678);
        xfer(32'h0001_0000, 1'b0, 32'h0,         2, 1'b0, 32'hDEAD_BEEF);
        xfer(32'h0007_0000, 1'b0, 32'h0,         0, 1'b0, 32'hFFFF_FFFF);
        xfer(32'h0003_0004, 1'b0, 32'h0,         0, 1'b1, 32'hCAFE_F00D);
        xfer(32'hFFF0_0008, 1'b1, 32'h0BAD_0BAD, 1, 1'b0, 32'h5555_AAAA);
        if (TOUT_EN) begin
            xfer(32'h0000_0000, 1'b0, 32'h0,  1000,     1'b0, 32'h1111_1111);
            xfer(32'h0001_0020, 1'b0, 32'h0,  0,        1'b0, 32'h2222_2222);
            xfer(32'h0002_0000, 1'b0, 32'h0,  int'(TO) - 1, 1'b1, 32'h3333_3333);
            xfer(32'h0003_0000, 1'b1, 32'h77, int'(TO), 1'b0, 32'h4444_4444);
        end

        // Randomized transfers.
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            a[MB-1 -: 4] = 4'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (TOUT_EN && r == 9) w = int'(TO) + int'($urandom_range(0, 3));
            else if (r == 8) w = int'(TO) - 1;
            else w = int'($urandom_range(0, 3));
            xfer(a, 1'($urandom_range(0, 1)), $urandom, w, 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge PCLK);
                check("gap_pready", 64'(PREADY), 64'd0);
                noise(-1);
            end
        end

        // Reset asserted while a slave is in ACCESS.
        @(negedge PCLK);
        PADDR = 32'h0003_0040; PWRITE = 1'b0; PWDATA = '0; PSEL = 1'b1; PENABLE = 1'b0;
        noise(3); PREADYS[3] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge PCLK);
            PENABLE = 1'b1;
            noise(3); PREADYS[3] = 1'b0;
            ok = (PENABLES === 1'b1);
        end
        check("midrst_reached_access", 64'(ok), 64'd1);
        #2 PRESETN = 1'b0;
        #1 check_zero("midrst");
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETN = 1'b1;
        check_zero("midrst_rel");
        xfer(32'h0003_0044, 1'b0, 32'h0, 1, 1'b0, 32'h600D_600D);
        xfer(32'h0000_0000, 1'b1, 32'hABCD, 0, 1'b0, 32'h0);

        @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
